// File: rtl/signal_snapshot_pkg.sv
// Shared types for the snapshot capture FIFO.
// Probe widths here are the defaults used by the top level.
package signal_snapshot_pkg;

  localparam int W_WIDE_DEF = 128;
  localparam int W_MID_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE
  } state_t;

  typedef struct packed {
    logic                  b1;
    logic [W_MID_DEF-1:0]  mid;
    logic [W_WIDE_DEF-1:0] wide;
    logic [7:0]            seq;
  } sample_t;

endpackage

// File: rtl/snapshot_fifo.sv
// Generic DEPTH-entry FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module snapshot_fifo
  import signal_snapshot_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sample_t
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads as zero when empty so outputs idle at zero.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/signal_snapshot_fifo.sv
// Triggered burst capture of three probe groups into a
// small FIFO drained over a valid/ready port.
module signal_snapshot_fifo
  import signal_snapshot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int W_WIDE = W_WIDE_DEF,
  parameter int W_MID  = W_MID_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [7:0]        burst_len,
  input  logic              trig,
  input  logic              in_b1,
  input  logic [W_MID-1:0]  in_mid,
  input  logic [W_WIDE-1:0] in_wide,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_b1,
  output logic [W_MID-1:0]  out_mid,
  output logic [W_WIDE-1:0] out_wide,
  output logic [7:0]        out_seq,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  typedef struct packed {
    logic              b1;
    logic [W_MID-1:0]  mid;
    logic [W_WIDE-1:0] wide;
    logic [7:0]        seq;
  } smp_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] len_q;
  logic [7:0] cnt_q;
  logic [7:0] seq_q;
  logic       done_q;
  logic       take;
  logic       last;
  logic       pop;
  logic       full;
  logic       empty;
  smp_t       smp;
  smp_t       head;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // abort beats trig; arm only matters in IDLE.
  always_comb begin
    state_n = state;
    take    = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) state_n = ARMED;
      end
      ARMED: begin
        if (abort) begin
          state_n = IDLE;
        end else if (trig) begin
          take    = 1'b1;
          last    = (len_q == 8'd1);
          state_n = last ? IDLE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          take    = 1'b1;
          last    = (cnt_q + 8'd1 == len_q);
          state_n = last ? IDLE : CAPTURE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q    <= 8'd1;
      cnt_q    <= '0;
      seq_q    <= '0;
      drop_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= take && last;
      if (state == IDLE && arm) begin
        len_q    <= (burst_len == 8'd0) ? 8'd1 : burst_len;
        cnt_q    <= '0;
        seq_q    <= '0;
        drop_cnt <= '0;
      end
      if (take) begin
        cnt_q <= cnt_q + 8'd1;
        seq_q <= seq_q + 8'd1;
      end
      if (take && full && !pop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign smp = '{b1: in_b1, mid: in_mid,
                 wide: in_wide, seq: seq_q};

  snapshot_fifo #(
    .DEPTH (DEPTH),
    .T     (smp_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (take),
    .push_data (smp),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;
  assign out_b1    = head.b1;
  assign out_mid   = head.mid;
  assign out_wide  = head.wide;
  assign out_seq   = head.seq;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_signal_snapshot_fifo.sv
// Bench for signal_snapshot_fifo: vector table, corner
// sequences and random traffic against a queue model.
module tb_signal_snapshot_fifo;

  localparam int DEPTH = 4;
  localparam int WW    = 128;
  localparam int WM    = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          trig = 1'b0;
  logic [7:0]    burst_len = '0;
  logic          in_b1 = 1'b0;
  logic [WM-1:0] in_mid = '0;
  logic [WW-1:0] in_wide = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_b1;
  logic [WM-1:0] out_mid;
  logic [WW-1:0] out_wide;
  logic [7:0]    out_seq;
  logic          busy;
  logic          done;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;

  signal_snapshot_fifo #(
    .DEPTH  (DEPTH),
    .W_WIDE (WW),
    .W_MID  (WM)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .arm       (arm),
    .abort     (abort),
    .burst_len (burst_len),
    .trig      (trig),
    .in_b1     (in_b1),
    .in_mid    (in_mid),
    .in_wide   (in_wide),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_b1    (out_b1),
    .out_mid   (out_mid),
    .out_wide  (out_wide),
    .out_seq   (out_seq),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of captured samples plus a
  // "samples left in this burst" count.
  typedef struct {
    logic          b1;
    logic [WM-1:0] mid;
    logic [WW-1:0] wide;
    int            seq;
  } ent_t;

  ent_t q[$];
  int   m_mode = 0;
  int   m_left = 0;
  int   m_seq  = 0;
  int   m_drop = 0;
  bit   m_done = 0;

  task automatic chk(input string n,
                     input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0;
    m_left = 0;
    m_seq  = 0;
    m_drop = 0;
    m_done = 0;
  endtask

  task automatic model_edge();
    bit   pop_now;
    bit   have;
    bit   nd;
    ent_t e;
    pop_now = (q.size() > 0) && out_ready;
    have = 0;
    nd   = 0;
    if (m_mode == 0) begin
      if (arm) begin
        m_mode = 1;
        m_left = (burst_len == 0) ? 1 : int'(burst_len);
        m_seq  = 0;
        m_drop = 0;
      end
    end else if (abort) begin
      m_mode = 0;
    end else if (m_mode == 2 || trig) begin
      have = 1;
      m_left--;
      if (m_left == 0) begin
        m_mode = 0;
        nd = 1;
      end else begin
        m_mode = 2;
      end
    end
    if (pop_now) q.delete(0);
    if (have) begin
      e.b1   = in_b1;
      e.mid  = in_mid;
      e.wide = in_wide;
      e.seq  = m_seq;
      m_seq  = (m_seq + 1) % 256;
      if (q.size() < DEPTH) q.push_back(e);
      else if (m_drop < 255) m_drop++;
    end
    m_done = nd;
  endtask

  task automatic check_model();
    logic          eb1;
    logic [WM-1:0] emid;
    logic [WW-1:0] ewide;
    logic [7:0]    eseq;
    eb1 = 0; emid = '0; ewide = '0; eseq = '0;
    if (q.size() > 0) begin
      eb1   = q[0].b1;
      emid  = q[0].mid;
      ewide = q[0].wide;
      eseq  = q[0].seq[7:0];
    end
    chk("m_valid", out_valid, q.size() > 0);
    chk("m_b1", out_b1, eb1);
    chk("m_mid", out_mid, emid);
    chk("m_wide", out_wide, ewide);
    chk("m_seq", out_seq, eseq);
    chk("m_busy", busy, m_mode != 0);
    chk("m_done", done, m_done);
    chk("m_drop", drop_cnt, m_drop[7:0]);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic clr();
    arm = 0;
    abort = 0;
    trig = 0;
  endtask

  task automatic drain(input int exp_pops);
    int pops;
    pops = 0;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) pops++;
      cycle();
    end
    chk("drain_pops", pops, exp_pops);
    chk("drain_empty", out_valid, 1'b0);
    out_ready = 0;
  endtask

  typedef struct {
    bit         arm;
    bit         trig;
    logic [7:0] len;
    logic [7:0] mid;
    bit         ev;
    logic [7:0] emid;
    logic [7:0] eseq;
    bit         ebusy;
    bit         edone;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{1, 0, 8'd3, 8'h00, 0, 8'h00, 8'd0, 1, 0};
    tv[1] = '{0, 1, 8'd0, 8'h11, 1, 8'h11, 8'd0, 1, 0};
    tv[2] = '{0, 0, 8'd0, 8'h22, 1, 8'h22, 8'd1, 1, 0};
    tv[3] = '{0, 0, 8'd0, 8'h33, 1, 8'h33, 8'd2, 0, 1};
    tv[4] = '{0, 0, 8'd0, 8'h44, 0, 8'h00, 8'd0, 0, 0};
    tv[5] = '{1, 0, 8'd0, 8'h00, 0, 8'h00, 8'd0, 1, 0};
    tv[6] = '{0, 1, 8'd0, 8'h55, 1, 8'h55, 8'd0, 0, 1};
    tv[7] = '{0, 0, 8'd0, 8'h66, 0, 8'h00, 8'd0, 0, 0};

    #12;
    check_model();
    reset = 1;

    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      arm       = tv[i].arm;
      trig      = tv[i].trig;
      burst_len = tv[i].len;
      in_mid    = tv[i].mid;
      in_b1     = tv[i].mid[0];
      in_wide   = {16{tv[i].mid}};
      cycle();
      chk("t_valid", out_valid, tv[i].ev);
      chk("t_mid", out_mid, tv[i].emid);
      chk("t_seq", out_seq, tv[i].eseq);
      chk("t_busy", busy, tv[i].ebusy);
      chk("t_done", done, tv[i].edone);
    end
    clr();

    // Overflow: 6 samples into 4 entries, no drain.
    out_ready = 0;
    arm = 1; burst_len = 8'd6;
    cycle();
    clr();
    trig = 1;
    for (int i = 0; i < 6; i++) begin
      in_mid  = 8'(8'hA0 + i);
      in_wide = {4{$urandom}};
      cycle();
      trig = 0;
    end
    chk("ovf_drop", drop_cnt, 8'd2);
    chk("ovf_seq", out_seq, 8'd0);
    chk("ovf_done", done, 1'b1);

    // Full FIFO, push and pop together.
    arm = 1; burst_len = 8'd1;
    cycle();
    clr();
    trig = 1; out_ready = 1; in_mid = 8'h5A;
    cycle();
    clr();
    out_ready = 0;
    chk("fp_drop", drop_cnt, 8'd0);
    chk("fp_seq", out_seq, 8'd1);
    chk("fp_done", done, 1'b1);
    drain(4);

    // Abort after three samples.
    arm = 1; burst_len = 8'd10;
    cycle();
    clr();
    trig = 1;
    for (int i = 0; i < 3; i++) begin
      in_mid = 8'(8'hC0 + i);
      cycle();
      trig = 0;
    end
    abort = 1;
    cycle();
    clr();
    chk("ab_busy", busy, 1'b0);
    chk("ab_done", done, 1'b0);
    cycle();
    chk("ab_done2", done, 1'b0);
    arm = 1; burst_len = 8'd2;
    cycle();
    clr();
    chk("ab_rearm", busy, 1'b1);
    abort = 1;
    cycle();
    clr();
    drain(3);

    // Reset in the middle of a burst.
    arm = 1; burst_len = 8'd10;
    cycle();
    clr();
    trig = 1;
    cycle();
    trig = 0;
    cycle();
    chk("rs_pre", out_valid, 1'b1);
    #2;
    reset = 0;
    #1;
    chk("rs_valid", out_valid, 1'b0);
    chk("rs_b1", out_b1, 1'b0);
    chk("rs_mid", out_mid, '0);
    chk("rs_wide", out_wide, '0);
    chk("rs_seq", out_seq, '0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_drop", drop_cnt, '0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int rmod;
      rmod      = (i / 200) % 3;
      arm       = ($urandom % 6) == 0;
      abort     = ($urandom % 25) == 0;
      trig      = ($urandom % 3) == 0;
      burst_len = (($urandom % 5) == 0) ? 8'($urandom)
                                          : 8'($urandom % 8);
      in_b1     = 1'($urandom);
      in_mid    = 8'($urandom);
      in_wide   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = (rmod == 0) ? 1'b1
                : (rmod == 1) ? (($urandom % 4) == 0)
                : 1'($urandom);
      cycle();
    end
    clr();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signal_snapshot_fifo.md
# signal_snapshot_fifo

Burst-capture stage sitting directly downstream of the signal-database test top. It samples a 1-bit, 8-bit and 128-bit probe group on a trigger, stores a burst of samples in a small FIFO, and drains them over a valid/ready port to the checker. The scoreboard then compares the drained values against the values written through the signal database.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- W_WIDE, 128, width of the wide probe.
- W_MID, 8, width of the mid probe.

Ports:
- clock, in, 1, sole clock; rising edge.
- reset, in, 1, asynchronous, active-low reset.
- arm, in, 1, one-cycle request to arm a capture.
- abort, in, 1, cancels the current arm/capture.
- burst_len, in, 8, number of samples per burst; latched at arm.
- trig, in, 1, capture trigger; qualified only while ARMED.
- in_b1, in, 1, 1-bit probe.
- in_mid, in, W_MID, mid probe.
- in_wide, in, W_WIDE, wide probe.
- out_valid, out, 1, FIFO head is valid.
- out_ready, in, 1, consumer accepts the head.
- out_b1, out, 1, head sample, 1-bit field.
- out_mid, out, W_MID, head sample, mid field.
- out_wide, out, W_WIDE, head sample, wide field.
- out_seq, out, 8, sequence number of the head sample.
- busy, out, 1, state is not IDLE.
- done, out, 1, one-cycle pulse when a burst completes.
- drop_cnt, out, 8, saturating count of samples dropped because the FIFO was full.

## Operation
- FSM states: IDLE, ARMED, CAPTURE.
  - IDLE -> ARMED on arm. At the same edge: latch burst_len (0 is treated as 1), clear the sequence counter, clear drop_cnt.
  - ARMED -> CAPTURE on trig. The probe values present in the trigger cycle are sample 0. If the latched length is 1, go directly to IDLE and pulse done.
  - CAPTURE: one sample per cycle, unconditionally, until the latched length is reached. Then go to IDLE and pulse done in the cycle after the last sample edge.
  - abort in ARMED or CAPTURE -> IDLE. No done pulse. A sample coinciding with abort is not taken. FIFO contents are retained.
  - abort has priority over trig, and trig over arm. arm outside IDLE is ignored.
- Every captured sample carries the sequence counter value, which then increments mod 256. A dropped sample also consumes a sequence number, so drops show up as gaps.
- Push when FIFO full and no pop in the same cycle: the sample is discarded and drop_cnt increments, saturating at 255.
- Full FIFO with a pop in the same cycle: the push is accepted.
- Pop occurs on out_valid && out_ready. The head fields and out_seq stay stable while out_valid is high and out_ready is low.
- The drain port runs independently of the FSM. Draining continues in IDLE.

## Timing
- Reset values: out_valid=0, out_b1=0, out_mid=0, out_wide=0, out_seq=0, busy=0, done=0, drop_cnt=0. FSM=IDLE, FIFO empty, pointers=0.
- Capture-to-output latency is 1 cycle. A sample pushed at edge N into an empty FIFO gives out_valid=1 with that data after edge N.
- busy goes high the cycle after the arm edge. It goes low in the same cycle that done is high.
- Pointers are log2(DEPTH) bits and wrap naturally. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Reset asserted mid-burst immediately clears the FIFO and FSM. No done pulse is issued.
- Throughput: one push and one pop per cycle, sustained.

## Structure
- Shared package signal_snapshot_pkg contains:
  - the state enum (IDLE/ARMED/CAPTURE);
  - the sample struct {b1, mid, wide, seq};
  - the W_WIDE/W_MID defaults.
- Sub-module snapshot_fifo: a generic DEPTH-entry FIFO of the sample struct with push/pop, full/empty, and simultaneous push+pop when full. The top level holds the FSM, sequence counter, drop counter and burst counter.

## Test plan
- Basic burst: arm with burst_len=3, trig with in_mid=0x11, 0x22, 0x33 in consecutive cycles, out_ready=1. Expect outputs 0x11/0x22/0x33 with seq 0/1/2, and done one cycle after the third sample.
- Zero length: arm with burst_len=0, then trig. Expect exactly one sample, seq 0, and done.
- Overflow: DEPTH=4, burst_len=6, out_ready=0. Expect 4 entries with seq 0..3 and drop_cnt=2. Then drain: exactly 4 pops, and out_valid=0 afterwards.
- Full FIFO with simultaneous pop: full FIFO, out_ready=1 during the capture cycle. Expect the push accepted and drop_cnt unchanged.
- Abort mid-capture: burst_len=10, abort after 3 samples. Expect 3 entries, no done pulse, busy=0 the next cycle, and a new arm accepted.
- Reset mid-burst: assert reset during CAPTURE with 2 entries stored. Expect all outputs at their reset values immediately, before the next clock edge.
